pp_carry_save_seq: RTL and testbench

PP_CARRY_SAVE_SEQ -- requirements
Module: pp_carry_save_seq

---
 rtl/pp_carry_save_seq_pkg.sv | 15 +
 rtl/full_adder.sv | 16 +
 rtl/pp_carry_save_seq_csa.sv | 30 +++
 rtl/pp_carry_save_seq.sv | 113 +++++++++++
 tb/tb_pp_carry_save_seq.sv | 315 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pp_carry_save_seq_pkg.sv
// Shared definitions for the sequential carry-save partial-product accumulator.
package pp_carry_save_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Operand width is half of the product width.
    function automatic int opWidthOf(input int inputWidth);
        return inputWidth / 2;
    endfunction

endpackage

// File: rtl/full_adder.sv
// Single-bit full adder cell, used as the per-column 3:2 counter.
module full_adder (
    input  logic i_a,
    input  logic i_b,
    input  logic i_cin,
    output logic o_sum,
    output logic o_cout
);

    // Sum is the parity of the three inputs; carry is their majority.
    always_comb begin
        o_sum  = i_a ^ i_b ^ i_cin;
        o_cout = (i_a & i_b) | (i_a & i_cin) | (i_b & i_cin);
    end

endmodule

// File: rtl/pp_carry_save_seq_csa.sv
// One row of 3:2 compression over product columns LEASTSIGNIFCOL..INPUTWIDTH-1.
// The carry row is the per-column majority moved up one column; the carry out
// of the top column is dropped, so that column needs only its parity.
module csa_row #(
    parameter int INPUTWIDTH     = 16,
    parameter int LEASTSIGNIFCOL = 0
) (
    input  logic [INPUTWIDTH-1:LEASTSIGNIFCOL] i_row0,
    input  logic [INPUTWIDTH-1:LEASTSIGNIFCOL] i_row1,
    input  logic [INPUTWIDTH-1:LEASTSIGNIFCOL] i_pp,
    output logic [INPUTWIDTH-1:LEASTSIGNIFCOL] o_sum,
    output logic [INPUTWIDTH-1:LEASTSIGNIFCOL] o_carry
);

    logic [INPUTWIDTH-2:LEASTSIGNIFCOL] w_maj;

    for (genvar j = LEASTSIGNIFCOL; j < INPUTWIDTH - 1; j++) begin : g_col
        full_adder u_fa (
            .i_a   (i_row0[j]),
            .i_b   (i_row1[j]),
            .i_cin (i_pp[j]),
            .o_sum (o_sum[j]),
            .o_cout(w_maj[j])
        );
    end

    assign o_sum[INPUTWIDTH-1] = i_row0[INPUTWIDTH-1] ^ i_row1[INPUTWIDTH-1] ^ i_pp[INPUTWIDTH-1];
    assign o_carry             = {w_maj, 1'b0};

endmodule

// File: rtl/pp_carry_save_seq.sv
// Sequential shift-and-add multiplier that accumulates one partial product per
// cycle into a carry-save pair of rows (row 1 = carry, row 0 = sum).
module pp_carry_save_seq
    import pp_carry_save_seq_pkg::*;
#(
    parameter int INPUTWIDTH     = 16,
    parameter int LEASTSIGNIFCOL = 0
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                in_valid,
    output logic                                in_ready,
    input  logic [opWidthOf(INPUTWIDTH)-1:0]    a,
    input  logic [opWidthOf(INPUTWIDTH)-1:0]    b,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic [INPUTWIDTH-1:LEASTSIGNIFCOL]  pp_accum [1:0]
);

    localparam int OPWIDTH = opWidthOf(INPUTWIDTH);
    localparam int CNTW    = $clog2(OPWIDTH) + 1;
    localparam logic [CNTW-1:0] LASTSTEP = CNTW'(OPWIDTH - 1);

    state_t                          r_state;
    state_t                          w_nextState;
    logic [OPWIDTH-1:0]              r_aReg;
    logic [OPWIDTH-1:0]              r_bReg;
    logic [CNTW-1:0]                 r_stepCnt;
    logic [INPUTWIDTH-1:LEASTSIGNIFCOL] r_row0;
    logic [INPUTWIDTH-1:LEASTSIGNIFCOL] r_row1;
    logic [INPUTWIDTH-1:0]           w_ppFull;
    logic [INPUTWIDTH-1:LEASTSIGNIFCOL] w_sum;
    logic [INPUTWIDTH-1:LEASTSIGNIFCOL] w_carry;

    // Current partial product: a shifted to the step column when that bit of b is set.
    always_comb begin
        w_ppFull = '0;
        for (int i = 0; i < OPWIDTH; i++) begin
            if (r_stepCnt == CNTW'(i) && r_bReg[i]) begin
                w_ppFull = {{(INPUTWIDTH - OPWIDTH){1'b0}}, r_aReg} << i;
            end
        end
    end

    csa_row #(
        .INPUTWIDTH    (INPUTWIDTH),
        .LEASTSIGNIFCOL(LEASTSIGNIFCOL)
    ) u_csa (
        .i_row0 (r_row0),
        .i_row1 (r_row1),
        .i_pp   (w_ppFull[INPUTWIDTH-1:LEASTSIGNIFCOL]),
        .o_sum  (w_sum),
        .o_carry(w_carry)
    );

    // State register; reset aborts any operation in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic: fixed OPWIDTH accumulate steps, then hold until consumed.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:    if (in_valid)              w_nextState = ACCUM;
            ACCUM:   if (r_stepCnt == LASTSTEP) w_nextState = DONE;
            DONE:    if (out_ready)             w_nextState = IDLE;
            default:                            w_nextState = IDLE;
        endcase
    end

    // Datapath: capture operands on accept, fold one partial product per ACCUM cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_aReg    <= '0;
            r_bReg    <= '0;
            r_stepCnt <= '0;
            r_row0    <= '0;
            r_row1    <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_aReg    <= a;
                        r_bReg    <= b;
                        r_stepCnt <= '0;
                        r_row0    <= '0;
                        r_row1    <= '0;
                    end
                end
                ACCUM: begin
                    r_row0 <= w_sum;
                    r_row1 <= w_carry;
                    if (r_stepCnt != LASTSTEP) begin
                        r_stepCnt <= r_stepCnt + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign in_ready    = (r_state == IDLE);
    assign out_valid   = (r_state == DONE);
    assign pp_accum[0] = r_row0;
    assign pp_accum[1] = r_row1;

endmodule

// File: tb/tb_pp_carry_save_seq.sv
// Self-checking bench for pp_carry_save_seq: directed cases plus randomized
// operand pairs checked against a plain-arithmetic product model.
module tb_pp_carry_save_seq;

    logic        clk;
    logic        rst_n;

    logic        inValid, inReady, outValid, outReady;
    logic [7:0]  a, b;
    logic [15:0] ppAcc [1:0];

    logic        inValidL, inReadyL, outValidL, outReadyL;
    logic [7:0]  aL, bL;
    logic [15:4] ppAccL [1:0];

    int vectors;
    int miscompares;

    pp_carry_save_seq #(.INPUTWIDTH(16), .LEASTSIGNIFCOL(0)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (inValid),
        .in_ready (inReady),
        .a        (a),
        .b        (b),
        .out_valid(outValid),
        .out_ready(outReady),
        .pp_accum (ppAcc)
    );

    pp_carry_save_seq #(.INPUTWIDTH(16), .LEASTSIGNIFCOL(4)) dutL (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (inValidL),
        .in_ready (inReadyL),
        .a        (aL),
        .b        (bL),
        .out_valid(outValidL),
        .out_ready(outReadyL),
        .pp_accum (ppAccL)
    );

    // Free-running clock, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference: sum of b-selected shifted copies of a, columns below lsc removed, mod 2^16.
    function automatic logic [15:0] refSum(input logic [7:0] ra, input logic [7:0] rb, input int lsc);
        logic [15:0] acc;
        logic [15:0] mask;
        acc  = '0;
        mask = 16'hFFFF << lsc;
        for (int i = 0; i < 8; i++) begin
            if (rb[i]) acc = acc + ((16'(ra) << i) & mask);
        end
        return acc;
    endfunction

    // Offer one pair to the LSC=0 instance and wait (bounded) for the result.
    // Optionally jiggles in_valid/a/b while accumulating and holds off out_ready.
    task automatic runOp(input logic [7:0] opA, input logic [7:0] opB, input bit noise,
                         output int lat, output logic [15:0] sumOut,
                         output logic [15:0] row0, output logic [15:0] row1);
        inValid = 1'b1;
        a = opA;
        b = opB;
        @(posedge clk);
        #1;
        inValid = 1'b0;
        lat = 0;
        while (!outValid && lat < 50) begin
            if (noise) begin
                inValid = 1'($urandom);
                a = 8'($urandom);
                b = 8'($urandom);
            end
            @(posedge clk);
            #1;
            lat++;
        end
        inValid = 1'b0;
        row0   = ppAcc[0];
        row1   = ppAcc[1];
        sumOut = ppAcc[1] + ppAcc[0];
        outReady = 1'b1;
        @(posedge clk);
        #1;
        outReady = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if (inReady !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL reset_in_ready got %b want 1", inReady);
        end
        vectors++;
        if (outValid !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_out_valid got %b want 0", outValid);
        end
        vectors++;
        if (ppAcc[0] !== 16'h0 || ppAcc[1] !== 16'h0) begin
            miscompares++;
            $display("[TB] FAIL reset_rows got %h/%h want 0000/0000", ppAcc[1], ppAcc[0]);
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic();
        int lat;
        logic [15:0] s, r0, r1;
        runOp(8'hFF, 8'hFF, 1'b0, lat, s, r0, r1);
        vectors++;
        if (lat !== 8) begin
            miscompares++;
            $display("[TB] FAIL basic_latency got %0d want 8", lat);
        end
        vectors++;
        if (s !== 16'hFE01) begin
            miscompares++;
            $display("[TB] FAIL basic_ff_ff got %h want fe01", s);
        end
    endtask

    task automatic test_lsc();
        int lat;
        logic [15:0] s;
        logic [15:0] want;
        want = refSum(8'h0F, 8'h0F, 4);
        inValidL = 1'b1;
        aL = 8'h0F;
        bL = 8'h0F;
        @(posedge clk);
        #1;
        inValidL = 1'b0;
        lat = 0;
        while (!outValidL && lat < 50) begin
            @(posedge clk);
            #1;
            lat++;
        end
        s = {ppAccL[1], 4'h0} + {ppAccL[0], 4'h0};
        vectors++;
        if (lat !== 8) begin
            miscompares++;
            $display("[TB] FAIL lsc_latency got %0d want 8", lat);
        end
        vectors++;
        if (s !== want || s !== 16'h00B0) begin
            miscompares++;
            $display("[TB] FAIL lsc4_0f_0f got %h want %h", s, want);
        end
        outReadyL = 1'b1;
        @(posedge clk);
        #1;
        outReadyL = 1'b0;
        vectors++;
        if (inReadyL !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL lsc_return_idle got %b want 1", inReadyL);
        end
    endtask

    task automatic test_zero();
        int lat;
        logic [15:0] s, r0, r1;
        runOp(8'h00, 8'hA5, 1'b0, lat, s, r0, r1);
        vectors++;
        if (lat !== 8) begin
            miscompares++;
            $display("[TB] FAIL zero_latency got %0d want 8", lat);
        end
        vectors++;
        if (r0 !== 16'h0 || r1 !== 16'h0) begin
            miscompares++;
            $display("[TB] FAIL zero_rows got %h/%h want 0000/0000", r1, r0);
        end
    endtask

    task automatic test_backpressure();
        int lat;
        logic [15:0] r0, r1;
        inValid = 1'b1;
        a = 8'h37;
        b = 8'h5C;
        @(posedge clk);
        #1;
        inValid = 1'b0;
        lat = 0;
        while (!outValid && lat < 50) begin
            @(posedge clk);
            #1;
            lat++;
        end
        r0 = ppAcc[0];
        r1 = ppAcc[1];
        vectors++;
        if (16'(r1 + r0) !== 16'h13C4) begin
            miscompares++;
            $display("[TB] FAIL bp_product got %h want 13c4", 16'(r1 + r0));
        end
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            vectors++;
            if (ppAcc[0] !== r0 || ppAcc[1] !== r1 || inReady !== 1'b0 || outValid !== 1'b1) begin
                miscompares++;
                $display("[TB] FAIL bp_hold_%0d got rows %h/%h rdy %b vld %b want %h/%h rdy 0 vld 1",
                         k, ppAcc[1], ppAcc[0], inReady, outValid, r1, r0);
            end
        end
        outReady = 1'b1;
        @(posedge clk);
        #1;
        outReady = 1'b0;
        vectors++;
        if (inReady !== 1'b1 || outValid !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL bp_release got rdy %b vld %b want rdy 1 vld 0", inReady, outValid);
        end
    endtask

    task automatic test_abort();
        int lat;
        int seen;
        logic [15:0] s, r0, r1;
        inValid = 1'b1;
        a = 8'hAA;
        b = 8'h55;
        @(posedge clk);
        #1;
        inValid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        vectors++;
        if (inReady !== 1'b1 || outValid !== 1'b0 || ppAcc[0] !== 16'h0 || ppAcc[1] !== 16'h0) begin
            miscompares++;
            $display("[TB] FAIL abort_state got rdy %b vld %b rows %h/%h want 1 0 0000/0000",
                     inReady, outValid, ppAcc[1], ppAcc[0]);
        end
        seen = 0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk);
            #1;
            if (outValid) seen++;
        end
        vectors++;
        if (seen !== 0) begin
            miscompares++;
            $display("[TB] FAIL abort_no_valid got %0d valid cycles want 0", seen);
        end
        runOp(8'h12, 8'h34, 1'b0, lat, s, r0, r1);
        vectors++;
        if (s !== 16'h03A8 || lat !== 8) begin
            miscompares++;
            $display("[TB] FAIL abort_next_op got %h lat %0d want 03a8 lat 8", s, lat);
        end
    endtask

    task automatic test_random();
        int lat;
        logic [15:0] s, r0, r1;
        logic [7:0] ra, rb;
        for (int n = 0; n < 2000; n++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            runOp(ra, rb, 1'b1, lat, s, r0, r1);
            vectors++;
            if (s !== 16'(ra * rb) || lat !== 8) begin
                miscompares++;
                $display("[TB] FAIL random_%0d %h*%h got %h lat %0d want %h lat 8",
                         n, ra, rb, s, lat, 16'(ra * rb));
            end
        end
    endtask

    // Run every scenario in order, then report.
    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n     = 1'b0;
        inValid   = 1'b0;
        outReady  = 1'b0;
        a         = '0;
        b         = '0;
        inValidL  = 1'b0;
        outReadyL = 1'b0;
        aL        = '0;
        bL        = '0;
        @(posedge clk);
        #1;
        test_reset();
        test_basic();
        test_lsc();
        test_zero();
        test_backpressure();
        test_abort();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
